// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter: FSM states, port ids
// and the legal memory-latency range.
package dmem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_t;

   typedef enum logic {
      PORT_CPU = 1'b0,
      PORT_DBG = 1'b1
   } port_t;

   localparam int MEM_LAT_DEF = 2;
   localparam int MEM_LAT_MIN = 1;
   localparam int MEM_LAT_MAX = 15;
   // lat_cnt width: wide enough for MEM_LAT_MAX-1
   localparam int LAT_W       = 4;

   function automatic port_t other_port(input port_t p);
      return (p == PORT_CPU) ? PORT_DBG : PORT_CPU;
   endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of the CPU, debug and memory-side signals of the data-memory arbiter.
// slave = arbiter side, master = requesters plus the memory itself.
interface dmem_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              cpu_req_i;
   logic              cpu_we_i;
   logic [ADDR_W-1:0] cpu_addr_i;
   logic [DATA_W-1:0] cpu_wdata_i;
   logic [DATA_W-1:0] cpu_rdata_o;
   logic              cpu_ack_o;
   logic              cpu_stall_o;

   logic              dbg_req_i;
   logic              dbg_we_i;
   logic [ADDR_W-1:0] dbg_addr_i;
   logic [DATA_W-1:0] dbg_wdata_i;
   logic [DATA_W-1:0] dbg_rdata_o;
   logic              dbg_ack_o;

   logic              mem_en_o;
   logic              mem_we_o;
   logic [ADDR_W-1:0] mem_addr_o;
   logic [DATA_W-1:0] mem_wdata_o;
   logic [DATA_W-1:0] mem_rdata_i;

   modport slave (
      input  cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i,
      output cpu_rdata_o, cpu_ack_o, cpu_stall_o,
      input  dbg_req_i, dbg_we_i, dbg_addr_i, dbg_wdata_i,
      output dbg_rdata_o, dbg_ack_o,
      output mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
      input  mem_rdata_i
   );

   modport master (
      output cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i,
      input  cpu_rdata_o, cpu_ack_o, cpu_stall_o,
      output dbg_req_i, dbg_we_i, dbg_addr_i, dbg_wdata_i,
      input  dbg_rdata_o, dbg_ack_o,
      input  mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
      output mem_rdata_i
   );

endinterface

// File: rtl/dmem_arb_rr.sv
// Two-input round-robin picker: a lone request wins outright, a tie goes to
// the port that was not granted last time. Purely combinational.
module dmem_arb_rr
   import dmem_arb_pkg::*;
(
   input  logic  cpu_req,
   input  logic  dbg_req,
   input  port_t last_grant,
   output port_t winner
);

   always_comb begin
      winner = PORT_CPU;
      if (cpu_req && dbg_req) begin
         winner = other_port(last_grant);
      end else if (dbg_req) begin
         winner = PORT_DBG;
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter/sequencer sharing the single-port data memory between the
// CPU MEM stage and the debug port. DMEM_ARB_PERF_EN adds stall/debug counters.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int MEM_LAT = MEM_LAT_DEF
) (
   input  logic clk_i,
   input  logic rst_i,
`ifdef DMEM_ARB_PERF_EN
   output logic [31:0] perf_stall_o,
   output logic [31:0] perf_dbg_o,
`endif
   dmem_arbiter_if.slave bus
);

   localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(MEM_LAT - 1);

   state_t            state_reg, state_next;
   logic [LAT_W-1:0]  lat_cnt_reg, lat_cnt_next;
   port_t             winner_reg, winner_next;
   port_t             last_grant_reg, last_grant_next;
   port_t             rr_winner;
   logic              we_reg, we_next;
   logic [ADDR_W-1:0] addr_reg, addr_next;
   logic [DATA_W-1:0] wdata_reg, wdata_next;
   logic [DATA_W-1:0] cpu_rdata_reg, cpu_rdata_next;
   logic [DATA_W-1:0] dbg_rdata_reg, dbg_rdata_next;

   logic busy;
   logic cpu_ack;
   logic dbg_ack;
   logic cpu_stall;

   dmem_arb_rr u_rr (
      .cpu_req    (bus.cpu_req_i),
      .dbg_req    (bus.dbg_req_i),
      .last_grant (last_grant_reg),
      .winner     (rr_winner)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_reg      <= IDLE;
         lat_cnt_reg    <= '0;
         winner_reg     <= PORT_CPU;
         last_grant_reg <= PORT_DBG;
         we_reg         <= 1'b0;
         addr_reg       <= '0;
         wdata_reg      <= '0;
         cpu_rdata_reg  <= '0;
         dbg_rdata_reg  <= '0;
      end else begin
         state_reg      <= state_next;
         lat_cnt_reg    <= lat_cnt_next;
         winner_reg     <= winner_next;
         last_grant_reg <= last_grant_next;
         we_reg         <= we_next;
         addr_reg       <= addr_next;
         wdata_reg      <= wdata_next;
         cpu_rdata_reg  <= cpu_rdata_next;
         dbg_rdata_reg  <= dbg_rdata_next;
      end
   end

   always_comb begin
      state_next      = state_reg;
      lat_cnt_next    = lat_cnt_reg;
      winner_next     = winner_reg;
      last_grant_next = last_grant_reg;
      we_next         = we_reg;
      addr_next       = addr_reg;
      wdata_next      = wdata_reg;
      cpu_rdata_next  = cpu_rdata_reg;
      dbg_rdata_next  = dbg_rdata_reg;

      case (state_reg)
         IDLE: begin
            if (bus.cpu_req_i || bus.dbg_req_i) begin
               winner_next  = rr_winner;
               lat_cnt_next = LAT_LOAD;
               state_next   = BUSY;
               // Byte offset is dropped at latch time so the memory sees word addresses
               if (rr_winner == PORT_CPU) begin
                  we_next    = bus.cpu_we_i;
                  addr_next  = {bus.cpu_addr_i[ADDR_W-1:2], 2'b00};
                  wdata_next = bus.cpu_wdata_i;
               end else begin
                  we_next    = bus.dbg_we_i;
                  addr_next  = {bus.dbg_addr_i[ADDR_W-1:2], 2'b00};
                  wdata_next = bus.dbg_wdata_i;
               end
            end
         end
         BUSY: begin
            if (lat_cnt_reg == '0) begin
               if (!we_reg) begin
                  if (winner_reg == PORT_CPU) begin
                     cpu_rdata_next = bus.mem_rdata_i;
                  end else begin
                     dbg_rdata_next = bus.mem_rdata_i;
                  end
               end
               state_next = RESP;
            end else begin
               lat_cnt_next = lat_cnt_reg - 1'b1;
            end
         end
         RESP: begin
            last_grant_next = winner_reg;
            state_next      = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Memory controls decode straight from state so they fall with an async reset
   assign busy      = (state_reg == BUSY);
   assign cpu_ack   = (state_reg == RESP) && (winner_reg == PORT_CPU);
   assign dbg_ack   = (state_reg == RESP) && (winner_reg == PORT_DBG);
   assign cpu_stall = bus.cpu_req_i & ~cpu_ack;

   assign bus.mem_en_o    = busy;
   assign bus.mem_we_o    = busy & we_reg;
   assign bus.mem_addr_o  = addr_reg;
   assign bus.mem_wdata_o = wdata_reg;

   assign bus.cpu_ack_o   = cpu_ack;
   assign bus.dbg_ack_o   = dbg_ack;
   assign bus.cpu_stall_o = cpu_stall;
   assign bus.cpu_rdata_o = cpu_rdata_reg;
   assign bus.dbg_rdata_o = dbg_rdata_reg;

`ifdef DMEM_ARB_PERF_EN
   // Slot 0 counts stalled cycles, slot 1 counts completed debug accesses
   logic [1:0]  perf_inc;
   logic [31:0] perf_cnt_reg [2];

   assign perf_inc[0] = cpu_stall;
   assign perf_inc[1] = dbg_ack;

   genvar gi;
   for (gi = 0; gi < 2; gi++) begin : g_perf
      always_ff @(posedge clk_i or posedge rst_i) begin
         if (rst_i) begin
            perf_cnt_reg[gi] <= '0;
         end else if (perf_inc[gi] && (perf_cnt_reg[gi] != 32'hFFFF_FFFF)) begin
            perf_cnt_reg[gi] <= perf_cnt_reg[gi] + 32'd1;
         end
      end
   end

   assign perf_stall_o = perf_cnt_reg[0];
   assign perf_dbg_o   = perf_cnt_reg[1];
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a MEM_LAT=2 and a MEM_LAT=1 instance, each checked every
// cycle against a transaction-level model, plus directed literal checks.
module tb_dmem_arbiter;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus0 ();
   dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus1 ();

`ifdef DMEM_ARB_PERF_EN
   logic [31:0] perf_stall [2];
   logic [31:0] perf_dbg   [2];
`endif

   dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2)) u_dut0 (
      .clk_i        (clk),
      .rst_i        (rst),
`ifdef DMEM_ARB_PERF_EN
      .perf_stall_o (perf_stall[0]),
      .perf_dbg_o   (perf_dbg[0]),
`endif
      .bus          (bus0)
   );

   dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) u_dut1 (
      .clk_i        (clk),
      .rst_i        (rst),
`ifdef DMEM_ARB_PERF_EN
      .perf_stall_o (perf_stall[1]),
      .perf_dbg_o   (perf_dbg[1]),
`endif
      .bus          (bus1)
   );

   // Simple RAMs behind each instance: combinational read, write on enabled edges
   logic [31:0] ram0 [64];
   logic [31:0] ram1 [64];
   assign bus0.mem_rdata_i = ram0[bus0.mem_addr_o[7:2]];
   assign bus1.mem_rdata_i = ram1[bus1.mem_addr_o[7:2]];

   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 64; i++) ram0[i] <= '0;
      end else if (bus0.mem_en_o && bus0.mem_we_o) begin
         ram0[bus0.mem_addr_o[7:2]] <= bus0.mem_wdata_o;
      end
   end

   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 64; i++) ram1[i] <= '0;
      end else if (bus1.mem_en_o && bus1.mem_we_o) begin
         ram1[bus1.mem_addr_o[7:2]] <= bus1.mem_wdata_o;
      end
   end

   task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s dut%0d @%0t: got %h expected %h", nm, d, $time, act, exp);
      end
   endtask

   // ---------------- transaction-level reference model ----------------
   typedef struct {
      logic        cpu_req, cpu_we, dbg_req, dbg_we;
      logic        cpu_ack, dbg_ack, stall, en, we;
      logic [31:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;
      logic [31:0] cpu_rd, dbg_rd, addr, wdata, pstall, pdbg;
   } snap_t;

   // pos: 0 = free, 1..lat = memory cycles, lat+1 = acknowledge cycle
   int          lat [2] = '{2, 1};
   int          pos [2];
   bit          win [2];
   bit          last [2];
   bit          awe [2];
   logic [31:0] aaddr [2];
   logic [31:0] awd [2];
   logic [31:0] erd_c [2];
   logic [31:0] erd_d [2];
   logic [31:0] eps [2];
   logic [31:0] epd [2];
   logic [31:0] ref_mem [2][64];

   task automatic step(input int d, input snap_t s);
      bit e_en, e_cack, e_dack, e_stall;
      if (rst) begin
         pos[d] = 0; last[d] = 1'b1;
         erd_c[d] = '0; erd_d[d] = '0; eps[d] = '0; epd[d] = '0;
         for (int i = 0; i < 64; i++) ref_mem[d][i] = '0;
         chk("rst_mem_en", d, 32'(s.en), 32'd0);
         chk("rst_cpu_ack", d, 32'(s.cpu_ack), 32'd0);
         chk("rst_dbg_ack", d, 32'(s.dbg_ack), 32'd0);
         chk("rst_cpu_rdata", d, s.cpu_rd, 32'd0);
         chk("rst_dbg_rdata", d, s.dbg_rd, 32'd0);
         return;
      end
      if (pos[d] == lat[d] + 1) begin
         if (awe[d]) ref_mem[d][aaddr[d][7:2]] = awd[d];
         else if (win[d]) erd_d[d] = ref_mem[d][aaddr[d][7:2]];
         else erd_c[d] = ref_mem[d][aaddr[d][7:2]];
      end
      e_en    = (pos[d] >= 1) && (pos[d] <= lat[d]);
      e_cack  = (pos[d] == lat[d] + 1) && !win[d];
      e_dack  = (pos[d] == lat[d] + 1) && win[d];
      e_stall = s.cpu_req && !e_cack;
      chk("mem_en", d, 32'(s.en), 32'(e_en));
      chk("cpu_ack", d, 32'(s.cpu_ack), 32'(e_cack));
      chk("dbg_ack", d, 32'(s.dbg_ack), 32'(e_dack));
      chk("cpu_stall", d, 32'(s.stall), 32'(e_stall));
      chk("cpu_rdata", d, s.cpu_rd, erd_c[d]);
      chk("dbg_rdata", d, s.dbg_rd, erd_d[d]);
      if (e_en) begin
         chk("mem_addr", d, s.addr, aaddr[d] & 32'hFFFF_FFFC);
         chk("mem_we", d, 32'(s.we), 32'(awe[d]));
         chk("mem_wdata", d, s.wdata, awd[d]);
      end
`ifdef DMEM_ARB_PERF_EN
      chk("perf_stall", d, s.pstall, eps[d]);
      chk("perf_dbg", d, s.pdbg, epd[d]);
`endif
      if (e_stall && eps[d] != 32'hFFFF_FFFF) eps[d] = eps[d] + 1;
      if (e_dack && epd[d] != 32'hFFFF_FFFF) epd[d] = epd[d] + 1;
      // advance to the next cycle
      if (pos[d] == 0) begin
         if (s.cpu_req || s.dbg_req) begin
            if (s.cpu_req && s.dbg_req) win[d] = !last[d];
            else win[d] = s.dbg_req;
            awe[d]   = win[d] ? s.dbg_we : s.cpu_we;
            aaddr[d] = win[d] ? s.dbg_addr : s.cpu_addr;
            awd[d]   = win[d] ? s.dbg_wdata : s.cpu_wdata;
            pos[d]   = 1;
         end
      end else if (pos[d] == lat[d] + 1) begin
         last[d] = win[d];
         pos[d]  = 0;
      end else begin
         pos[d] = pos[d] + 1;
      end
   endtask

   always @(negedge clk) begin
      snap_t s0, s1;
      s0.cpu_req = bus0.cpu_req_i;   s1.cpu_req = bus1.cpu_req_i;
      s0.cpu_we = bus0.cpu_we_i;     s1.cpu_we = bus1.cpu_we_i;
      s0.dbg_req = bus0.dbg_req_i;   s1.dbg_req = bus1.dbg_req_i;
      s0.dbg_we = bus0.dbg_we_i;     s1.dbg_we = bus1.dbg_we_i;
      s0.cpu_ack = bus0.cpu_ack_o;   s1.cpu_ack = bus1.cpu_ack_o;
      s0.dbg_ack = bus0.dbg_ack_o;   s1.dbg_ack = bus1.dbg_ack_o;
      s0.stall = bus0.cpu_stall_o;   s1.stall = bus1.cpu_stall_o;
      s0.en = bus0.mem_en_o;         s1.en = bus1.mem_en_o;
      s0.we = bus0.mem_we_o;         s1.we = bus1.mem_we_o;
      s0.cpu_addr = bus0.cpu_addr_i; s1.cpu_addr = bus1.cpu_addr_i;
      s0.cpu_wdata = bus0.cpu_wdata_i; s1.cpu_wdata = bus1.cpu_wdata_i;
      s0.dbg_addr = bus0.dbg_addr_i; s1.dbg_addr = bus1.dbg_addr_i;
      s0.dbg_wdata = bus0.dbg_wdata_i; s1.dbg_wdata = bus1.dbg_wdata_i;
      s0.cpu_rd = bus0.cpu_rdata_o;  s1.cpu_rd = bus1.cpu_rdata_o;
      s0.dbg_rd = bus0.dbg_rdata_o;  s1.dbg_rd = bus1.dbg_rdata_o;
      s0.addr = bus0.mem_addr_o;     s1.addr = bus1.mem_addr_o;
      s0.wdata = bus0.mem_wdata_o;   s1.wdata = bus1.mem_wdata_o;
`ifdef DMEM_ARB_PERF_EN
      s0.pstall = perf_stall[0];     s1.pstall = perf_stall[1];
      s0.pdbg = perf_dbg[0];         s1.pdbg = perf_dbg[1];
`else
      s0.pstall = '0; s1.pstall = '0; s0.pdbg = '0; s1.pdbg = '0;
`endif
      step(0, s0);
      step(1, s1);
   end

   // ---------------- directed stimulus ----------------
   int          order [8];
   int          stall_seen;
   logic [31:0] ps_a, ps_b, pd_a, pd_b;

   // One access on dut0 from the given port (0 = CPU, 1 = DBG)
   task automatic acc0(input bit port, input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                       output logic [31:0] rd, output logic [31:0] ma, output int n, output int nstall);
      bit done = 1'b0;
      @(posedge clk); #1;
      if (port) begin
         bus0.dbg_req_i = 1'b1; bus0.dbg_we_i = we; bus0.dbg_addr_i = addr; bus0.dbg_wdata_i = wdata;
      end else begin
         bus0.cpu_req_i = 1'b1; bus0.cpu_we_i = we; bus0.cpu_addr_i = addr; bus0.cpu_wdata_i = wdata;
      end
      n = 0; nstall = 0; ma = '0; rd = '0;
      while (!done && n < 20) begin
         @(negedge clk);
         n++;
         if (bus0.mem_en_o) ma = bus0.mem_addr_o;
         if (!port && bus0.cpu_stall_o) nstall++;
         if (port ? bus0.dbg_ack_o : bus0.cpu_ack_o) begin
            rd = port ? bus0.dbg_rdata_o : bus0.cpu_rdata_o;
            done = 1'b1;
         end
      end
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL acc_timeout port%0d: no ack within 20 cycles, required ack", port);
      end
      @(posedge clk); #1;
      bus0.cpu_req_i = 1'b0;
      bus0.dbg_req_i = 1'b0;
   endtask

   // Both dut0 ports request continuously until n acks have been seen
   task automatic run_both(input int n);
      int acks = 0;
      int cyc = 0;
      @(posedge clk); #1;
`ifdef DMEM_ARB_PERF_EN
      ps_a = perf_stall[0]; pd_a = perf_dbg[0];
`endif
      bus0.cpu_req_i = 1'b1; bus0.cpu_we_i = 1'b0; bus0.cpu_addr_i = 32'h4; bus0.cpu_wdata_i = '0;
      bus0.dbg_req_i = 1'b1; bus0.dbg_we_i = 1'b1; bus0.dbg_addr_i = 32'h10; bus0.dbg_wdata_i = 32'hA5;
      stall_seen = 0;
      while (acks < n && cyc < 100) begin
         @(negedge clk);
         cyc++;
         if (bus0.cpu_stall_o) stall_seen++;
         if (bus0.cpu_ack_o || bus0.dbg_ack_o) begin
            chk("dual_ack", 0, 32'(bus0.cpu_ack_o & bus0.dbg_ack_o), 32'd0);
            order[acks] = bus0.dbg_ack_o ? 1 : 0;
            acks++;
         end
      end
      checks++;
      if (acks < n) begin
         errors++;
         $display("FAIL both_timeout: got %0d acks, required %0d", acks, n);
      end
      @(posedge clk); #1;
`ifdef DMEM_ARB_PERF_EN
      ps_b = perf_stall[0]; pd_b = perf_dbg[0];
`endif
      bus0.cpu_req_i = 1'b0;
      bus0.dbg_req_i = 1'b0;
   endtask

   initial begin
      logic [31:0] rd, ma;
      int n, ns;
      int exp_order [6] = '{0, 1, 0, 1, 0, 1};
      int en_cyc [4];
      int ne, acks, cyc;

      bus0.cpu_req_i = 0; bus0.cpu_we_i = 0; bus0.cpu_addr_i = '0; bus0.cpu_wdata_i = '0;
      bus0.dbg_req_i = 0; bus0.dbg_we_i = 0; bus0.dbg_addr_i = '0; bus0.dbg_wdata_i = '0;
      bus1.cpu_req_i = 0; bus1.cpu_we_i = 0; bus1.cpu_addr_i = '0; bus1.cpu_wdata_i = '0;
      bus1.dbg_req_i = 0; bus1.dbg_we_i = 0; bus1.dbg_addr_i = '0; bus1.dbg_wdata_i = '0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // Preload via debug, then timed CPU load
      acc0(1'b1, 1'b1, 32'h4, 32'h1234, rd, ma, n, ns);
      $display("dbg store 0x04=0x1234: %0d cycles", n);
      acc0(1'b0, 1'b0, 32'h4, 32'h0, rd, ma, n, ns);
      $display("cpu load 0x04: rdata=%h ack after %0d cycles, %0d stall cycles", rd, n, ns);
      chk("cpu_load_latency", 0, 32'(n), 32'd4);
      chk("cpu_load_stall_cycles", 0, 32'(ns), 32'd3);
      chk("cpu_load_rdata", 0, rd, 32'h1234);

      // Byte offset ignored on both ports
      acc0(1'b1, 1'b1, 32'h8, 32'd5, rd, ma, n, ns);
      $display("dbg store 0x08=5: mem_addr=%h", ma);
      chk("dbg_store_mem_addr", 0, ma, 32'h8);
      acc0(1'b0, 1'b0, 32'hA, 32'h0, rd, ma, n, ns);
      $display("cpu load 0x0A: mem_addr=%h rdata=%h", ma, rd);
      chk("cpu_load_a_mem_addr", 0, ma, 32'h8);
      chk("cpu_load_a_rdata", 0, rd, 32'd5);
      acc0(1'b1, 1'b0, 32'h8, 32'h0, rd, ma, n, ns);
      $display("dbg load 0x08: rdata=%h", rd);
      chk("dbg_load_rdata", 0, rd, 32'd5);

      // Continuous contention: last grant was DBG, so CPU goes first
      run_both(6);
      for (int i = 0; i < 6; i++) begin
         $display("contention grant %0d -> %s", i, order[i] ? "DBG" : "CPU");
         chk("rr_order", 0, 32'(order[i]), 32'(exp_order[i]));
      end
`ifdef DMEM_ARB_PERF_EN
      $display("perf: dbg delta=%0d stall delta=%0d counted=%0d", pd_b - pd_a, ps_b - ps_a, stall_seen);
      chk("perf_dbg_delta", 0, pd_b - pd_a, 32'd3);
      chk("perf_stall_delta", 0, ps_b - ps_a, 32'(stall_seen));
`endif

      // Reset in the middle of a store
      @(posedge clk); #1;
      bus0.cpu_req_i = 1'b1; bus0.cpu_we_i = 1'b1; bus0.cpu_addr_i = 32'h20; bus0.cpu_wdata_i = 32'hDEAD;
      @(posedge clk); #1;
      chk("busy_before_rst", 0, 32'(bus0.mem_en_o), 32'd1);
      rst = 1'b1;
      #1;
      $display("reset mid-access: mem_en=%b cpu_ack=%b", bus0.mem_en_o, bus0.cpu_ack_o);
      chk("rst_async_mem_en", 0, 32'(bus0.mem_en_o), 32'd0);
      chk("rst_async_ack", 0, 32'(bus0.cpu_ack_o), 32'd0);
      bus0.cpu_req_i = 1'b0; bus0.cpu_we_i = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      run_both(2);
      $display("after reset: first grant %s, second %s", order[0] ? "DBG" : "CPU", order[1] ? "DBG" : "CPU");
      chk("first_grant_after_rst", 0, 32'(order[0]), 32'd0);
      chk("second_grant_after_rst", 0, 32'(order[1]), 32'd1);

      // MEM_LAT=1 instance: three back-to-back CPU stores
      @(posedge clk); #1;
      bus1.cpu_req_i = 1'b1; bus1.cpu_we_i = 1'b1; bus1.cpu_addr_i = 32'h30; bus1.cpu_wdata_i = 32'd1;
      ne = 0; acks = 0; cyc = 0;
      while (acks < 3 && cyc < 30) begin
         @(negedge clk);
         cyc++;
         if (bus1.mem_en_o && ne < 4) begin
            en_cyc[ne] = cyc;
            ne++;
         end
         if (bus1.cpu_ack_o) begin
            acks++;
            @(posedge clk); #1;
            if (acks == 3) begin
               bus1.cpu_req_i = 1'b0;
            end else begin
               bus1.cpu_addr_i = bus1.cpu_addr_i + 32'd4;
               bus1.cpu_wdata_i = bus1.cpu_wdata_i + 32'd1;
            end
         end
      end
      bus1.cpu_req_i = 1'b0;
      $display("lat1 stores: %0d acks, %0d mem_en pulses", acks, ne);
      chk("lat1_acks", 1, 32'(acks), 32'd3);
      chk("lat1_en_pulses", 1, 32'(ne), 32'd3);
      if (ne >= 3) begin
         chk("lat1_spacing_a", 1, 32'(en_cyc[1] - en_cyc[0]), 32'd3);
         chk("lat1_spacing_b", 1, 32'(en_cyc[2] - en_cyc[1]), 32'd3);
      end

      repeat (3) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, required normal completion");
      $fatal(1);
   end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Arbiter and sequencer for the single-port data memory of the pipelined CPU. It shares the memory between two requesters: the CPU MEM stage (port 0) and a debug/loader port (port 1) that the bench uses to preload and inspect memory. Each accepted access runs for a fixed multi-cycle latency. While a CPU access is pending, the block drives the pipeline stall.

## Interface
- ADDR_W, 32, byte address width
- DATA_W, 32, data word width
- MEM_LAT, 2, memory access cycles; legal range 1..15
- clk_i  in  1  clock; all state updates on the rising edge
- rst_i  in  1  asynchronous reset, active-high
- cpu_req_i  in  1  CPU access request; level-sensitive
- cpu_we_i  in  1  1 = store, 0 = load
- cpu_addr_i  in  ADDR_W  byte address; bits [1:0] ignored
- cpu_wdata_i  in  DATA_W  store data
- cpu_rdata_o  out  DATA_W  load data
- cpu_ack_o  out  1  one-cycle completion pulse
- cpu_stall_o  out  1  pipeline stall to the hazard unit
- dbg_req_i, dbg_we_i, dbg_addr_i, dbg_wdata_i, dbg_rdata_o, dbg_ack_o  debug port; same widths and meanings as the cpu_* signals
- mem_en_o  out  1  memory enable
- mem_we_o  out  1  memory write enable
- mem_addr_o  out  ADDR_W  word-aligned address; bits [1:0] forced to 0
- mem_wdata_o  out  DATA_W  write data
- mem_rdata_i  in  DATA_W  read data; valid on the last access cycle

## Operation
- FSM states: IDLE, BUSY, RESP.
- IDLE
  - If any req is high, pick a winner and latch its we/addr/wdata.
  - Load lat_cnt = MEM_LAT-1 and go to BUSY.
  - If no req is high, stay in IDLE.
- Arbitration is round-robin.
  - One request high: that requester wins.
  - Both high: the port not granted last time wins.
  - last_grant resets to DBG, so the CPU wins the first tie.
- BUSY
  - mem_en_o=1. mem_we_o/addr/wdata come from the latched values.
  - lat_cnt decrements each cycle.
  - When lat_cnt==0, capture mem_rdata_i into the winner's rdata register (loads only) and go to RESP.
- RESP
  - Assert the winner's ack for exactly one cycle, update last_grant, go to IDLE.
- A requester must hold req and its fields stable until it sees ack.
- After ack, req is sampled again in the following IDLE cycle. A requester that keeps req high therefore issues a new access.
- cpu_rdata_o and dbg_rdata_o hold their value until the next load completes on the same port. Stores do not change them.
- cpu_stall_o = cpu_req_i & ~cpu_ack_o. It is combinational from the state and req, and covers the arbitration wait, the BUSY cycles, and any wait behind a debug access.
- Reset values
  - All outputs 0; state IDLE; lat_cnt 0; rdata registers 0; last_grant DBG.
- Reset mid-access: the access is aborted with no ack. mem_en_o drops asynchronously with rst_i.
- A request that drops before ack is a protocol violation. The latched access still completes and acks.

## Timing
- Request high in IDLE at edge N: the winner's ack is high in the cycle after edge N+MEM_LAT+1.
- Total occupancy is MEM_LAT+2 cycles per access, including IDLE.
- Back-to-back accesses from one port: MEM_LAT+2 cycles apart.
- Both ports requesting continuously: grants alternate CPU, DBG, CPU, and so on.
- MEM_LAT=1: BUSY lasts exactly one cycle.

## Configuration
- DMEM_ARB_PERF_EN defined:
  - Adds output perf_stall_o[31:0], which counts cycles with cpu_stall_o=1.
  - Adds output perf_dbg_o[31:0], which counts completed debug accesses.
  - Both counters reset to 0 and saturate at 32'hFFFFFFFF.
- DMEM_ARB_PERF_EN undefined: these ports and counters are absent. All other behaviour is identical.

## Structure
- Package dmem_arb_pkg holds:
  - the state enum (IDLE/BUSY/RESP);
  - the port-id enum (PORT_CPU=0, PORT_DBG=1);
  - the MEM_LAT default and legal bound constants.
- Sub-module dmem_arb_rr: two-input round-robin picker. Inputs are the requests and last_grant; output is the winner. Purely combinational.

## Test plan
- CPU load alone, MEM_LAT=2, mem word at 0x04 = 32'h1234: ack 4 cycles after the request; cpu_rdata_o=32'h1234; stall high for the 3 cycles before ack.
- Debug store to 0x08 of 5, then CPU load from 0x0A: mem_addr_o=0x08 for both accesses; CPU reads 5.
- Both ports request continuously for 6 accesses: grants go CPU, DBG, CPU, DBG, CPU, DBG; no ack on both ports in the same cycle.
- rst_i asserted during BUSY: mem_en_o drops immediately; no ack; FSM is in IDLE after release; the first grant goes to the CPU.
- MEM_LAT=1, CPU holds req for 3 back-to-back stores: mem_en_o pulses 3 times, 3 cycles apart.
- DMEM_ARB_PERF_EN defined, run of the 6-access case: perf_dbg_o=3 and perf_stall_o equals the counted cpu_stall_o cycles.
